led_chaser_engine: RTL and testbench
====================================

LED_CHASER_ENGINE -- requirements
Module: led_chaser_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of LEDs (legal range 2..32).
REQ-002 SHALL have parameter DIV_FACTOR, default 1200000, meaning the prescaler period in clk cycles (legal range 2..2^CNT_W).
REQ-003 SHALL have parameter CNT_W, default 24, meaning the prescaler counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: run enable; low freezes the prescaler and the pattern.
REQ-007 SHALL have port mode, input, 2 bits: 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill.
REQ-008 SHALL have port speed, input, 2 bits: one step per 1/2/4/8 prescaler ticks for 00/01/10/11.
REQ-009 SHALL have port led, output, WIDTH bits, registered, active-low (0 = lit).
REQ-010 SHALL have port step_tick, output, 1 bit, registered: high for exactly one cycle on each pattern step.

Function
REQ-011 SHALL keep an internal active-high pattern register pat[WIDTH-1:0], with led == ~pat at all times.
REQ-012 Prescaler: counts 0..DIV_FACTOR-1 while en=1; at DIV_FACTOR-1 it wraps to 0 and emits one internal tick.
REQ-013 Speed divider: a 3-bit tick counter; a step occurs on the tick at which the tick count reaches 1/2/4/8 per the speed value sampled at that tick, after which the count clears.
REQ-014 A speed change mid-count: if the current count already meets or exceeds the new threshold, the step occurs on the next tick.
REQ-015 On each step: pat updates; step_tick=1 in the same cycle as the new led value.
REQ-016 Rotate-left: pat <= {pat[WIDTH-2:0], pat[WIDTH-1]}; MSB wraps to LSB.
REQ-017 Rotate-right: pat <= {pat[0], pat[WIDTH-1:1]}; LSB wraps to MSB.
REQ-018 Ping-pong: states GO_LEFT and GO_RIGHT; single lit LED moves toward MSB in GO_LEFT.
REQ-019 In ping-pong, when bit WIDTH-1 is reached the state becomes GO_RIGHT; when bit 0 is reached it becomes GO_LEFT; endpoints are not repeated (sequence 0,1,..,W-1,W-2,..,0,1..).
REQ-020 Fill: pat <= {pat[WIDTH-2:0],1'b1} until all ones; the step after all-ones yields all-zeros (all LEDs off); the step after all-zeros yields 0..01.
REQ-021 A mode change is detected against a registered copy mode_q; in the following cycle pat <= 0..01, ping-pong state <= GO_LEFT, prescaler and tick counter <= 0, step_tick=0.
REQ-022 If a mode change and a step fall in the same cycle, the mode-change restart wins and no step is taken.
REQ-023 en=0: prescaler, tick counter, pat and FSM hold; step_tick=0; mode-change restart still applies.
REQ-024 Latency: the first step after reset or restart occurs DIV_FACTOR*N cycles later with en held high, where N is set by speed.

Reset
REQ-025 On rst=1 at a clk edge: pat=0..01 (led = all ones except led[0]=0), step_tick=0, prescaler=0, tick counter=0, FSM=GO_LEFT, mode_q=mode.
REQ-026 Reset mid-operation SHALL take priority over en, steps and mode changes; no step_tick in the reset cycle.

Configuration
REQ-027 Macro LED_CHASER_PINGPONG_EN: when defined, mode 10 is ping-pong per REQ-018..019.
REQ-028 Without LED_CHASER_PINGPONG_EN, mode 10 SHALL behave identically to rotate-left and the ping-pong FSM logic SHALL be absent.

Verification (WIDTH=8, DIV_FACTOR=4 unless stated)
REQ-029 rst=1 for 2 cycles, then en=1, mode=00, speed=00 -> led=1111_1110, then 1111_1101 after 4 cycles with a single step_tick pulse; 1111_1110 again after 8 steps.
REQ-030 mode=01, speed=10 -> step every 16 cycles; led 1111_1110 -> 0111_1111 -> 1011_1111.
REQ-031 mode=10 (macro defined) -> lit index 0..7,6..0,1 over 15 steps, with no duplicated endpoints; macro undefined -> same stimulus gives the rotate-left sequence.
REQ-032 mode=11 -> led 1111_1110, 1111_1100, ..., 0000_0000, then 1111_1111, then 1111_1110.
REQ-033 Mode switch 00->01 at a step cycle -> next cycle led=1111_1110, step_tick=0, next step 4 cycles later.
REQ-034 en=0 for 10 cycles mid-count, then en=1 -> led is unchanged during the pause and the step resumes with the remaining count; rst pulse mid-fill -> led=1111_1110.

Source files
------------

// File: rtl/led_chaser_engine.sv
// -----------------------------------------------------------------------------
// led_chaser_engine
//
// Purpose:
//   Drives a row of WIDTH active-low LEDs with a stepping light pattern. A
//   prescaler divides clk down to an internal tick. A small tick counter then
//   divides that tick by 1/2/4/8 to produce pattern steps. Four patterns are
//   supported: rotate-left, rotate-right, ping-pong and fill.
//
// Parameters:
//   WIDTH      - number of LEDs (2..32)
//   DIV_FACTOR - prescaler period in clk cycles (2..2^CNT_W)
//   CNT_W      - prescaler counter width
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   en         - run enable; low freezes prescaler, tick counter and pattern
//   mode[1:0]  - 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill
//   speed[1:0] - one step per 1/2/4/8 prescaler ticks
//   led        - registered LED drive, active-low (0 = lit)
//   step_tick  - registered, one-cycle pulse coinciding with each new led value
//
// Build option:
//   LED_CHASER_PINGPONG_EN - when defined, mode 10 is a bouncing single LED.
//                            When undefined, mode 10 is rotate-left and the
//                            direction FSM is not built.
// -----------------------------------------------------------------------------
module led_chaser_engine #(
   parameter int WIDTH      = 8,
   parameter int DIV_FACTOR = 1200000,
   parameter int CNT_W      = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   output logic [WIDTH-1:0] led,
   output logic             step_tick
);

   localparam logic [1:0] MODE_ROL  = 2'b00;
   localparam logic [1:0] MODE_ROR  = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;
   localparam logic [1:0] MODE_FILL = 2'b11;

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DIV_FACTOR - 1);
   localparam logic [WIDTH-1:0] PAT_INIT   = WIDTH'(1);

`ifdef LED_CHASER_PINGPONG_EN
   localparam logic [0:0] GO_LEFT  = 1'b0;
   localparam logic [0:0] GO_RIGHT = 1'b1;
`endif

   // Number of prescaler ticks per step for a given speed code.
   function automatic logic [3:0] speed_threshold(input logic [1:0] s);
      return 4'd1 << s;
   endfunction

   logic [CNT_W-1:0] presc_q, presc_d;
   logic [2:0]       tcnt_q, tcnt_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] led_q, led_d;
   logic             step_tick_q, step_tick_d;
   logic [1:0]       mode_q, mode_d;

`ifdef LED_CHASER_PINGPONG_EN
   logic [0:0]       dir_q, dir_d, dir_nxt;
`endif

   logic             presc_tick;
   logic             mode_change;
   logic             step;
   logic [3:0]       tcnt_next;
   logic [WIDTH-1:0] pat_nxt;

   // Pattern that the next step would produce from the current state.
   always_comb begin
      pat_nxt = pat_q;
`ifdef LED_CHASER_PINGPONG_EN
      dir_nxt = dir_q;
`endif
      case (mode_q)
         MODE_ROR: pat_nxt = {pat_q[0], pat_q[WIDTH-1:1]};
         MODE_FILL: begin
            // Fill up to all-ones, then one all-dark step, then start over.
            if (&pat_q)
               pat_nxt = '0;
            else if (pat_q == '0)
               pat_nxt = PAT_INIT;
            else
               pat_nxt = {pat_q[WIDTH-2:0], 1'b1};
         end
`ifdef LED_CHASER_PINGPONG_EN
         MODE_ROL: pat_nxt = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
         MODE_PING: begin
            // Direction flips on the step that lands on an end bit, so each
            // endpoint is shown once before the light turns around.
            if (dir_q == GO_LEFT) begin
               pat_nxt = {pat_q[WIDTH-2:0], 1'b0};
               if (pat_q[WIDTH-2])
                  dir_nxt = GO_RIGHT;
            end else begin
               pat_nxt = {1'b0, pat_q[WIDTH-1:1]};
               if (pat_q[1])
                  dir_nxt = GO_LEFT;
            end
         end
`else
         MODE_ROL, MODE_PING: pat_nxt = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
`endif
         default: pat_nxt = pat_q;
      endcase
   end

   always_comb begin
      presc_tick  = en && (presc_q == PRESC_LAST);
      tcnt_next   = {1'b0, tcnt_q} + 4'd1;
      // ">=" rather than "==" so a speed change to a lower threshold mid-count
      // steps on the very next tick instead of wrapping the counter.
      step        = presc_tick && (tcnt_next >= speed_threshold(speed));
      mode_change = (mode != mode_q);

      presc_d     = presc_q;
      tcnt_d      = tcnt_q;
      pat_d       = pat_q;
      step_tick_d = 1'b0;
      mode_d      = mode;
`ifdef LED_CHASER_PINGPONG_EN
      dir_d       = dir_q;
`endif

      // A mode change restarts everything and overrides any coincident step,
      // even while the engine is paused.
      if (mode_change) begin
         presc_d = '0;
         tcnt_d  = '0;
         pat_d   = PAT_INIT;
`ifdef LED_CHASER_PINGPONG_EN
         dir_d   = GO_LEFT;
`endif
      end else if (en) begin
         presc_d = presc_tick ? '0 : presc_q + CNT_W'(1);
         if (presc_tick) begin
            // Non-stepping ticks never exceed 7, so the 3-bit store is safe.
            tcnt_d = step ? 3'd0 : tcnt_next[2:0];
         end
         if (step) begin
            pat_d       = pat_nxt;
            step_tick_d = 1'b1;
`ifdef LED_CHASER_PINGPONG_EN
            dir_d       = dir_nxt;
`endif
         end
      end

      // LED drive is its own flop so the output is a clean register.
      led_d = ~pat_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         tcnt_q      <= '0;
         pat_q       <= PAT_INIT;
         led_q       <= ~PAT_INIT;
         step_tick_q <= 1'b0;
         mode_q      <= mode;
`ifdef LED_CHASER_PINGPONG_EN
         dir_q       <= GO_LEFT;
`endif
      end else begin
         presc_q     <= presc_d;
         tcnt_q      <= tcnt_d;
         pat_q       <= pat_d;
         led_q       <= led_d;
         step_tick_q <= step_tick_d;
         mode_q      <= mode_d;
`ifdef LED_CHASER_PINGPONG_EN
         dir_q       <= dir_d;
`endif
      end
   end

   assign led       = led_q;
   assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_chaser_engine.sv
// -----------------------------------------------------------------------------
// tb_led_chaser_engine
//
// Directed bench for led_chaser_engine with WIDTH=8, DIV_FACTOR=4. Stimulus
// pushes the expected led value and the absolute cycle of every step into a
// scoreboard queue. A monitor pops and compares whenever step_tick is high.
// Restart, reset and pause conditions are checked directly by the stimulus.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_led_chaser_engine;

   localparam int W   = 8;
   localparam int DIV = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [1:0]   mode;
   logic [1:0]   speed;
   logic [W-1:0] led;
   logic         step_tick;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] led;
      int         at;
   } exp_t;

   exp_t sb[$];

   led_chaser_engine #(
      .WIDTH      (W),
      .DIV_FACTOR (DIV),
      .CNT_W      (24)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .speed     (speed),
      .led       (led),
      .step_tick (step_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_step(input logic [7:0] l, input int at);
      sb.push_back('{l, at});
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] led_of(input int idx);
      logic [7:0] one;
      one = 8'h01;
      return ~(one << idx);
   endfunction

   // Scoreboard monitor: each step_tick pulse must match the head entry.
   always @(negedge clk) begin
      if (step_tick === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_step: got led %0h with no step expected (cycle %0d)", led, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("step_led", {24'd0, led}, {24'd0, e.led});
            check("step_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      int c0;
      int idx;
      logic [7:0] fill_seq [11];
      fill_seq = '{8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80,
                   8'h00, 8'hFF, 8'hFE, 8'hFC, 8'hF8};

      rst   = 1'b1;
      en    = 1'b0;
      mode  = 2'b00;
      speed = 2'b00;
      wait_cyc(2);
      check("reset_led", {24'd0, led}, 32'hFE);
      check("reset_step_tick", {31'd0, step_tick}, 32'd0);

      // Rotate-left, one step per prescaler tick, full lap back to FE.
      rst = 1'b0;
      en  = 1'b1;
      c0  = cyc;
      for (int k = 1; k <= 8; k++) expect_step(led_of(k % 8), c0 + 4 * k);
      wait_cyc(32);

      // Mode switch landing exactly on a step cycle: restart wins.
      wait_cyc(3);
      mode = 2'b01;
      wait_cyc(1);
      check("switch_restart_led", {24'd0, led}, 32'hFE);
      check("switch_restart_step_tick", {31'd0, step_tick}, 32'd0);
      c0 = cyc;
      expect_step(8'h7F, c0 + 4);
      expect_step(8'hBF, c0 + 8);
      wait_cyc(8);

      // Rotate-right at speed 10: one step every 16 cycles.
      speed = 2'b10;
      c0    = cyc;
      expect_step(8'hDF, c0 + 16);
      expect_step(8'hEF, c0 + 32);
      wait_cyc(32);

      // Speed 11 for five ticks, then drop to 01: count already past 2.
      speed = 2'b11;
      c0    = cyc;
      wait_cyc(20);
      speed = 2'b01;
      expect_step(8'hF7, c0 + 24);
      expect_step(8'hFB, c0 + 32);
      wait_cyc(12);

      // Pause for 10 cycles with the prescaler at 2.
      speed = 2'b00;
      c0    = cyc;
      wait_cyc(2);
      en = 1'b0;
      expect_step(8'hFD, c0 + 14);
      wait_cyc(5);
      check("pause_led_mid", {24'd0, led}, 32'hFB);
      wait_cyc(5);
      check("pause_led_end", {24'd0, led}, 32'hFB);
      en = 1'b1;
      wait_cyc(2);

      // Fill mode through all-ones, dark, and restart of the fill.
      mode = 2'b11;
      wait_cyc(1);
      check("fill_restart_led", {24'd0, led}, 32'hFE);
      c0 = cyc;
      for (int k = 0; k < 11; k++) expect_step(fill_seq[k], c0 + 4 * (k + 1));
      wait_cyc(44);

      // Reset pulse in the middle of a fill.
      wait_cyc(2);
      rst = 1'b1;
      wait_cyc(1);
      check("midfill_reset_led", {24'd0, led}, 32'hFE);
      check("midfill_reset_step_tick", {31'd0, step_tick}, 32'd0);
      rst = 1'b0;
      c0  = cyc;
      expect_step(8'hFC, c0 + 4);
      wait_cyc(4);

      // Mode 10: ping-pong when built in, rotate-left otherwise.
      mode = 2'b10;
      wait_cyc(1);
      check("ping_restart_led", {24'd0, led}, 32'hFE);
      c0 = cyc;
      for (int k = 1; k <= 15; k++) begin
`ifdef LED_CHASER_PINGPONG_EN
         if (k <= 7)       idx = k;
         else if (k <= 14) idx = 14 - k;
         else              idx = 1;
`else
         idx = k % 8;
`endif
         expect_step(led_of(idx), c0 + 4 * k);
      end
      wait_cyc(60);

      // Mode change while paused still restarts; no steps while paused.
      en   = 1'b0;
      mode = 2'b00;
      wait_cyc(1);
      check("paused_restart_led", {24'd0, led}, 32'hFE);
      check("paused_restart_step_tick", {31'd0, step_tick}, 32'd0);
      wait_cyc(10);
      check("paused_hold_led", {24'd0, led}, 32'hFE);

      check("scoreboard_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
